// File: rtl/oversample_filter.sv
// Oversampling averager: sums 2^os_log ADC samples and emits their mean.
// Ports: clk_in/reset_in, data_in/data_valid_in in, os_log_in/update_in/
// update_en_in ratio control, clear_in frame abort, data_out/data_valid_out.
// Build option: define OS_ROUND_EN for round-half-up with saturation.
module oversample_filter #(
    parameter int W_DATA      = 18,
    parameter int W_OSL       = 4,
    parameter int MAX_OS_LOG  = 15,
    parameter int OS_LOG_INIT = 0
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic [W_DATA-1:0] data_in,
    input  logic              data_valid_in,
    input  logic [W_OSL-1:0]  os_log_in,
    input  logic              clear_in,
    input  logic              update_en_in,
    input  logic              update_in,
    output logic [W_DATA-1:0] data_out,
    output logic              data_valid_out
);

    localparam int W_ACC = W_DATA + MAX_OS_LOG;
    localparam int W_CNT = MAX_OS_LOG + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_SEND
    } state_t;

    state_t                    state_q, state_d;
    logic signed [W_ACC-1:0]   acc_q, acc_d;
    logic [W_CNT-1:0]          cnt_q, cnt_d;
    logic [W_OSL-1:0]          osl_act_q, osl_act_d;
    logic [W_OSL-1:0]          osl_pend_q, osl_pend_d;
    logic [W_DATA-1:0]         dout_q, dout_d;

    logic [W_OSL-1:0]          osl_req;
    logic signed [W_ACC-1:0]   smp_ext;
    logic [W_CNT-1:0]          len_act;
    logic [W_CNT-1:0]          cnt_inc;
    logic signed [W_ACC-1:0]   shifted;
    logic [W_DATA-1:0]         avg;
    logic                      send;
    logic                      start;

    assign osl_req = (32'(os_log_in) > 32'(MAX_OS_LOG))
                   ? W_OSL'(MAX_OS_LOG) : os_log_in;
    assign smp_ext = {{MAX_OS_LOG{data_in[W_DATA-1]}}, data_in};
    assign len_act = W_CNT'(1) << osl_act_q;
    assign cnt_inc = cnt_q + W_CNT'(1);

`ifdef OS_ROUND_EN
    localparam logic signed [W_ACC-1:0] AVG_MAX =
        {{(MAX_OS_LOG+1){1'b0}}, {(W_DATA-1){1'b1}}};

    logic [W_ACC-1:0]        half;
    logic signed [W_ACC-1:0] biased;

    // (1<<n)>>1 is 2^(n-1), and naturally 0 when n==0.
    assign half    = (W_ACC'(1) << osl_act_q) >> 1;
    assign biased  = acc_q + signed'(half);
    assign shifted = biased >>> osl_act_q;
    assign avg     = (shifted > AVG_MAX)
                   ? AVG_MAX[W_DATA-1:0] : shifted[W_DATA-1:0];
`else
    logic unused_hi;

    assign shifted   = acc_q >>> osl_act_q;
    assign avg       = shifted[W_DATA-1:0];
    // The mean of W_DATA-bit samples always fits in W_DATA bits.
    assign unused_hi = ^shifted[W_ACC-1:W_DATA];
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        osl_act_d  = osl_act_q;
        osl_pend_d = osl_pend_q;
        dout_d     = dout_q;
        send       = 1'b0;
        start      = 1'b0;

        if (update_in && update_en_in) begin
            osl_pend_d = osl_req;
        end

        unique case (state_q)
            ST_IDLE: begin
                osl_act_d = osl_pend_q;
                start     = data_valid_in;
            end
            ST_ACCUM: begin
                if (data_valid_in) begin
                    acc_d = acc_q + smp_ext;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_act) begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                send    = 1'b1;
                dout_d  = avg;
                state_d = ST_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                // A sample arriving with the pulse opens the next frame.
                start   = data_valid_in;
            end
            default: begin
                state_d = ST_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase

        // Frame start: the ratio is frozen here for the whole frame.
        if (start) begin
            acc_d     = smp_ext;
            cnt_d     = W_CNT'(1);
            osl_act_d = osl_pend_q;
            state_d   = (osl_pend_q == '0) ? ST_SEND : ST_ACCUM;
        end

        if (clear_in) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
            dout_d  = dout_q;
            send    = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            osl_act_q  <= W_OSL'(OS_LOG_INIT);
            osl_pend_q <= W_OSL'(OS_LOG_INIT);
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            osl_act_q  <= osl_act_d;
            osl_pend_q <= osl_pend_d;
            dout_q     <= dout_d;
        end
    end

    // The pulse cycle shows the fresh mean; otherwise the last one is held.
    assign data_valid_out = send;
    assign data_out       = send ? avg : dout_q;

endmodule

// File: tb/tb_oversample_filter.sv
// Bench for oversample_filter: directed cases plus random traffic,
// checked each cycle against a sum/count reference model.
module tb_oversample_filter;

    localparam int W   = 18;
    localparam int OSL = 5;
    localparam int MAXV = (1 << (W-1)) - 1;

    logic           clk_in = 1'b0;
    logic           reset_in;
    logic [W-1:0]   data_in;
    logic           data_valid_in;
    logic [OSL-1:0] os_log_in;
    logic           clear_in;
    logic           update_en_in;
    logic           update_in;
    logic [W-1:0]   data_out;
    logic           data_valid_out;

    int errors = 0;
    int checks = 0;

    oversample_filter #(
        .W_DATA(W), .W_OSL(OSL), .MAX_OS_LOG(15), .OS_LOG_INIT(0)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .data_in(data_in), .data_valid_in(data_valid_in),
        .os_log_in(os_log_in), .clear_in(clear_in),
        .update_en_in(update_en_in), .update_in(update_in),
        .data_out(data_out), .data_valid_out(data_valid_out)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: running sum and count of the open frame.
    longint msum = 0;
    int     mcnt = 0;
    int     mn = 0;
    int     mpend = 0;
    bit     mpulse = 0;
    int     mpval = 0;
    int     mlast = 0;
    int     mq[$];

    function automatic int mean(longint s, int n);
        longint d, q;
        d = longint'(1) << n;
`ifdef OS_ROUND_EN
        if (n > 0) s = s + d / 2;
`endif
        q = s / d;
        if ((s % d != 0) && s < 0) q = q - 1;
`ifdef OS_ROUND_EN
        if (q > MAXV) q = MAXV;
`endif
        return int'(q);
    endfunction

    always @(posedge clk_in) begin
        if (!reset_in) begin
            if (mpulse && !clear_in) mlast = mpval;
            mpulse = 0;
            if (clear_in) begin
                msum = 0;
                mcnt = 0;
            end else if (data_valid_in) begin
                if (mcnt == 0) mn = mpend;
                msum = msum + longint'($signed(data_in));
                mcnt = mcnt + 1;
                if (mcnt == (1 << mn)) begin
                    mpval = mean(msum, mn);
                    mpulse = 1;
                    mq.push_back(mpval);
                    msum = 0;
                    mcnt = 0;
                end
            end
            if (update_in && update_en_in)
                mpend = (int'(os_log_in) > 15) ? 15 : int'(os_log_in);
        end
    end

    always @(negedge clk_in) begin
        bit ev;
        int ed;
        if (reset_in) begin
            msum = 0; mcnt = 0; mn = 0; mpend = 0;
            mpulse = 0; mlast = 0;
        end
        ev = mpulse && !clear_in;
        ed = ev ? mpval : mlast;
        checks += 2;
        if (data_valid_out !== ev) begin
            errors++;
            $display("FAIL valid @%0t: got %b expected %b",
                     $time, data_valid_out, ev);
        end
        if (data_out !== W'(ed)) begin
            errors++;
            $display("FAIL data @%0t: got %0d expected %0d",
                     $time, $signed(data_out), ed);
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic int mq_at(input int i);
        if (i < mq.size()) return mq[i];
        return -999999;
    endfunction

    task automatic cyc(input bit v, input int d, input bit clr,
                       input bit upd, input int osl, input bit en);
        data_valid_in = v;
        data_in       = W'(d);
        clear_in      = clr;
        update_in     = upd;
        update_en_in  = en;
        os_log_in     = OSL'(osl);
        @(posedge clk_in);
        #1;
        data_valid_in = 0;
        clear_in      = 0;
        update_in     = 0;
    endtask

    task automatic samp(input int d);
        cyc(1, d, 0, 0, 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 1);
    endtask

    task automatic upd(input int osl);
        cyc(0, 0, 0, 1, osl, 1);
    endtask

    int base;

    initial begin
        reset_in = 1; data_in = '0; data_valid_in = 0; os_log_in = '0;
        clear_in = 0; update_en_in = 0; update_in = 0;
        #2;
        chk("reset_data", int'(data_out), 0);
        chk("reset_valid", int'(data_valid_out), 0);
        repeat (2) @(posedge clk_in);
        #1 reset_in = 0;
        idle(1);

        // pass-through ratio
        base = mq.size();
        samp(5); samp(-3); samp(7);
        idle(2);
        chk("pass0", mq_at(base), 5);
        chk("pass1", mq_at(base+1), -3);
        chk("pass2", mq_at(base+2), 7);

        // ratio 4, back-to-back frames
        upd(2);
        base = mq.size();
        samp(1); samp(2); samp(3); samp(4);
        samp(-1); samp(-2); samp(-3); samp(-4);
        idle(2);
`ifdef OS_ROUND_EN
        chk("os2_pos", mq_at(base), 3);
        chk("os2_neg", mq_at(base+1), -2);
`else
        chk("os2_pos", mq_at(base), 2);
        chk("os2_neg", mq_at(base+1), -3);
`endif

        // ratio 8, sparse valid
        upd(3);
        base = mq.size();
        repeat (8) begin samp(100); idle(1); end
        idle(2);
        chk("os3_cnt", mq.size() - base, 1);
        chk("os3_val", mq_at(base), 100);

        // ratio change mid-frame
        upd(2);
        base = mq.size();
        samp(4); samp(8);
        upd(1);
        samp(12); samp(16); samp(6); samp(8); samp(-5); samp(2);
        idle(2);
        chk("mid_f4", mq_at(base), 10);
        chk("mid_f2a", mq_at(base+1), 7);
`ifdef OS_ROUND_EN
        chk("mid_f2b", mq_at(base+2), -1);
`else
        chk("mid_f2b", mq_at(base+2), -2);
`endif

        // clamp and full-length frame of max samples
        upd(15);
        upd(20);
        base = mq.size();
        repeat (32768) samp(MAXV);
        idle(3);
        chk("clamp_cnt", mq.size() - base, 1);
        chk("clamp_val", mq_at(base), MAXV);

        // clear on the final sample
        upd(1);
        base = mq.size();
        samp(9);
        cyc(1, 11, 1, 0, 0, 1);
        samp(2); samp(4);
        idle(2);
        chk("clr_cnt", mq.size() - base, 1);
        chk("clr_val", mq_at(base), 3);

        // reset mid-frame
        base = mq.size();
        samp(50);
        reset_in = 1;
        #1;
        chk("rst_mid_data", int'(data_out), 0);
        @(posedge clk_in);
        #1 reset_in = 0;
        samp(21);
        idle(2);
        chk("rst_cnt", mq.size() - base, 1);
        chk("rst_val", mq_at(base), 21);

        // random traffic
        repeat (3000) begin
            int d;
            d = int'($urandom_range(0, 262143)) - 131072;
            cyc($urandom_range(0, 99) < 70, d,
                $urandom_range(0, 99) < 2,
                $urandom_range(0, 99) < 3,
                int'($urandom_range(0, 4)),
                $urandom_range(0, 3) != 0);
        end
        idle(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
